// File: rtl/muldiv_sched.sv
// muldiv_sched: shared iterative RV32M multiply/divide unit for the dual-issue
// pipeline. A scheduler picks lane 1 or lane 2, runs 32 radix-2 steps
// (shift-add multiply or restoring divide on magnitudes), and returns the
// result with its rd and lane tag. Divide-by-zero and signed overflow are
// resolved at accept and finish one cycle later.
module muldiv_sched #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            req1,
    input  logic            req2,
    input  logic [2:0]      op1,
    input  logic [2:0]      op2,
    input  logic [XLEN-1:0] a1,
    input  logic [XLEN-1:0] b1,
    input  logic [XLEN-1:0] a2,
    input  logic [XLEN-1:0] b2,
    input  logic [4:0]      rd1,
    input  logic [4:0]      rd2,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            lane_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONE   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  ALL_ZERO  = {XLEN{1'b0}};
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN-1);

    // Architectural state
    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          op_q;
    logic [4:0]          rd_q;
    logic                lane_q;
    logic [XLEN-1:0]     opnd_q;     // multiplicand or divisor magnitude
    logic [XLEN-1:0]     hi_q;       // product high half / partial remainder
    logic [XLEN-1:0]     lo_q;       // multiplier bits / dividend-to-quotient
    logic                qneg_q;     // negate product or quotient
    logic                rneg_q;     // negate remainder
    logic                done_q;
    logic [XLEN-1:0]     result_q;
    logic [4:0]          rd_out_q;
    logic                lane_out_q;
    logic                served1_q;
    logic                served2_q;

    // Accept-side selection
    logic                pend1_s;
    logic                pend2_s;
    logic                accept_s;
    logic                take2_s;
    logic [2:0]          sel_op_s;
    logic [XLEN-1:0]     sel_a_s;
    logic [XLEN-1:0]     sel_b_s;
    logic [4:0]          sel_rd_s;
    logic                a_sgn_s;
    logic                b_sgn_s;
    logic [XLEN-1:0]     ma_s;
    logic [XLEN-1:0]     mb_s;
    logic                special_s;
    logic [XLEN-1:0]     special_res_s;

    // Iteration datapath
    logic [XLEN:0]       sum_s;
    logic [XLEN:0]       rtmp_s;
    logic [XLEN-1:0]     diff_s;
    logic [XLEN-1:0]     step_hi_d;
    logic [XLEN-1:0]     step_lo_d;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quo_s;
    logic [XLEN-1:0]     rem_s;
    logic [XLEN-1:0]     fin_res_s;
    logic                fin1_s;
    logic                fin2_s;

    // Pick the pending lane (lane 1 is older), take operand magnitudes, detect special cases
    always_comb begin
        pend1_s  = req1 & ~served1_q;
        pend2_s  = req2 & ~served2_q;
        accept_s = pend1_s | pend2_s;
        take2_s  = ~pend1_s;
        if (take2_s) begin
            sel_op_s = op2;
            sel_a_s  = a2;
            sel_b_s  = b2;
            sel_rd_s = rd2;
        end else begin
            sel_op_s = op1;
            sel_a_s  = a1;
            sel_b_s  = b1;
            sel_rd_s = rd1;
        end
        case (sel_op_s)
            3'b001, 3'b100, 3'b110: begin
                a_sgn_s = sel_a_s[XLEN-1];
                b_sgn_s = sel_b_s[XLEN-1];
            end
            3'b010: begin
                a_sgn_s = sel_a_s[XLEN-1];
                b_sgn_s = 1'b0;
            end
            default: begin
                a_sgn_s = 1'b0;
                b_sgn_s = 1'b0;
            end
        endcase
        ma_s = a_sgn_s ? (-sel_a_s) : sel_a_s;
        mb_s = b_sgn_s ? (-sel_b_s) : sel_b_s;
        if (sel_op_s[2] && (sel_b_s == ALL_ZERO)) begin
            special_s     = 1'b1;
            special_res_s = sel_op_s[1] ? sel_a_s : ALL_ONE;
        end else if (sel_op_s[2] && !sel_op_s[0] && (sel_a_s == MIN_NEG) && (sel_b_s == ALL_ONE)) begin
            special_s     = 1'b1;
            special_res_s = sel_op_s[1] ? ALL_ZERO : MIN_NEG;
        end else begin
            special_s     = 1'b0;
            special_res_s = ALL_ZERO;
        end
    end

    // One radix-2 step (shift-add or restoring subtract) and the signed fix-up of the final value
    always_comb begin
        sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        rtmp_s = {hi_q, lo_q[XLEN-1]};
        diff_s = rtmp_s[XLEN-1:0] - opnd_q;
        if (op_q[2]) begin
            if (rtmp_s >= {1'b0, opnd_q}) begin
                step_hi_d = diff_s;
                step_lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                step_hi_d = rtmp_s[XLEN-1:0];
                step_lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi_d = sum_s[XLEN:1];
            step_lo_d = {sum_s[0], lo_q[XLEN-1:1]};
        end
        if (qneg_q) begin
            prod_s = -{step_hi_d, step_lo_d};
            quo_s  = -step_lo_d;
        end else begin
            prod_s = {step_hi_d, step_lo_d};
            quo_s  = step_lo_d;
        end
        if (rneg_q) begin
            rem_s = -step_hi_d;
        end else begin
            rem_s = step_hi_d;
        end
        if (op_q[2]) begin
            fin_res_s = op_q[1] ? rem_s : quo_s;
        end else if (op_q == 3'b000) begin
            fin_res_s = prod_s[XLEN-1:0];
        end else begin
            fin_res_s = prod_s[2*XLEN-1:XLEN];
        end
    end

    // Result outputs and the combinational pipeline stall (a squashed FIN delivers nothing)
    always_comb begin
        done     = done_q & ~flush;
        result   = result_q;
        rd_out   = rd_out_q;
        lane_out = lane_out_q;
        fin1_s   = served1_q | (done & ~lane_out_q);
        fin2_s   = served2_q | (done & lane_out_q);
        stall    = (req1 & ~fin1_s) | (req2 & ~fin2_s);
    end

    // Scheduler FSM, iteration registers, served bookkeeping and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            op_q       <= 3'b000;
            rd_q       <= 5'd0;
            lane_q     <= 1'b0;
            opnd_q     <= ALL_ZERO;
            hi_q       <= ALL_ZERO;
            lo_q       <= ALL_ZERO;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= ALL_ZERO;
            rd_out_q   <= 5'd0;
            lane_out_q <= 1'b0;
            served1_q  <= 1'b0;
            served2_q  <= 1'b0;
        end else if (flush) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            done_q    <= 1'b0;
            served1_q <= 1'b0;
            served2_q <= 1'b0;
        end else begin
            // Once the pipeline advances, both lanes hold new instructions
            if (!stall) begin
                served1_q <= 1'b0;
                served2_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (accept_s) begin
                        op_q   <= sel_op_s;
                        rd_q   <= sel_rd_s;
                        lane_q <= take2_s;
                        qneg_q <= a_sgn_s ^ b_sgn_s;
                        rneg_q <= a_sgn_s;
                        cnt_q  <= {CNT_W{1'b0}};
                        opnd_q <= sel_op_s[2] ? mb_s : ma_s;
                        hi_q   <= ALL_ZERO;
                        lo_q   <= sel_op_s[2] ? ma_s : mb_s;
                        if (special_s) begin
                            state_q    <= S_FIN;
                            done_q     <= 1'b1;
                            result_q   <= special_res_s;
                            rd_out_q   <= sel_rd_s;
                            lane_out_q <= take2_s;
                        end else begin
                            state_q <= S_CALC;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CALC: begin
                    hi_q <= step_hi_d;
                    lo_q <= step_lo_d;
                    if (cnt_q == LAST_STEP) begin
                        state_q    <= S_FIN;
                        cnt_q      <= {CNT_W{1'b0}};
                        done_q     <= 1'b1;
                        result_q   <= fin_res_s;
                        rd_out_q   <= rd_q;
                        lane_out_q <= lane_q;
                    end else begin
                        state_q <= S_CALC;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    // The other lane is still waiting: remember this one is finished
                    if (stall) begin
                        if (lane_out_q) begin
                            served2_q <= 1'b1;
                        end else begin
                            served1_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: randomized self-checking bench for muldiv_sched with a
// plain-arithmetic RV32M reference model.
module tb_muldiv_sched;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req1, req2, flush;
    logic [2:0]  op1, op2;
    logic [31:0] a1, b1, a2, b2;
    logic [4:0]  rd1, rd2;
    logic        stall, done, lane_out;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] MINV = 32'h8000_0000;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    always #5 CLK = ~CLK;

    muldiv_sched #(.XLEN(32), .CNT_W(6)) dut (
        .CLK(CLK), .RST(RST),
        .req1(req1), .req2(req2), .op1(op1), .op2(op2),
        .a1(a1), .b1(b1), .a2(a2), .b2(b2),
        .rd1(rd1), .rd2(rd2), .flush(flush),
        .stall(stall), .done(done), .result(result),
        .rd_out(rd_out), .lane_out(lane_out)
    );

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        r = 32'd0;
        case (op)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = ONES;
                else if (a == MINV && b == ONES) r = MINV;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: begin
                if (b == 32'd0) r = ONES;
                else begin p = ua / ub; r = p[31:0]; end
            end
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == MINV && b == ONES) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 32'd0) r = a;
                else begin p = ua % ub; r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 32'd0 || (!op[0] && a == MINV && b == ONES))) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return MINV;
            2: return ONES;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input bit lane2, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        if (lane2) begin
            req2 = 1'b1; op2 = op; a2 = a; b2 = b; rd2 = rd;
        end else begin
            req1 = 1'b1; op1 = op; a1 = a; b1 = b; rd1 = rd;
        end
    endtask

    // Waits for done from the current cycle (cycle 0); reports latency, outputs, stall at done
    task automatic wait_done(output int cyc, output logic [31:0] res, output logic [4:0] rdo,
                             output logic ln, output logic st, output bit early);
        bit got;
        int c;
        got = 0; c = 0; early = 0;
        res = 32'd0; rdo = 5'd0; ln = 1'b0; st = 1'b0;
        while (!got && c < 100) begin
            @(negedge CLK);
            if (done === 1'b1) begin
                got = 1; res = result; rdo = rd_out; ln = lane_out; st = stall;
            end else begin
                if (stall !== 1'b1) early = 1;
                @(posedge CLK); #1;
                c++;
            end
        end
        cyc = got ? c : -1;
    endtask

    task automatic release_reqs();
        @(posedge CLK); #1;
        req1 = 1'b0; req2 = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; req1 = 1'b0; req2 = 1'b0; flush = 1'b0;
        op1 = 3'd0; op2 = 3'd0; a1 = 32'd0; b1 = 32'd0; a2 = 32'd0; b2 = 32'd0;
        rd1 = 5'd0; rd2 = 5'd0;
        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        checks++; if ({rd_out, lane_out} !== 6'd0) begin errors++; $display("FAIL reset_tag: got %h want 0", {rd_out, lane_out}); end
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_mul_basic();
        int cyc; logic [31:0] r; logic [4:0] rdo; logic ln, st; bit early;
        drive(1'b0, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        wait_done(cyc, r, rdo, ln, st, early);
        checks++; if (cyc != 33) begin errors++; $display("FAIL mul_latency: got %0d want 33", cyc); end
        checks++; if (r !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h want ffffffeb", r); end
        checks++; if ({ln, rdo} !== {1'b0, 5'd5}) begin errors++; $display("FAIL mul_tag: got %b/%0d want 0/5", ln, rdo); end
        checks++; if (early) begin errors++; $display("FAIL mul_stall_early: got low want high"); end
        checks++; if (st !== 1'b0) begin errors++; $display("FAIL mul_stall_done: got %b want 0", st); end
        release_reqs();
    endtask

    task automatic test_mulh_lane2();
        int cyc; logic [31:0] r; logic [4:0] rdo; logic ln, st; bit early;
        drive(1'b1, 3'd3, ONES, ONES, 5'd9);
        wait_done(cyc, r, rdo, ln, st, early);
        checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu_result: got %h want fffffffe", r); end
        checks++; if ({ln, rdo} !== {1'b1, 5'd9}) begin errors++; $display("FAIL mulhu_tag: got %b/%0d want 1/9", ln, rdo); end
        release_reqs();
        drive(1'b1, 3'd1, ONES, ONES, 5'd10);
        wait_done(cyc, r, rdo, ln, st, early);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL mulh_result: got %h want 00000000", r); end
        checks++; if (cyc != 33) begin errors++; $display("FAIL mulh_latency: got %0d want 33", cyc); end
        release_reqs();
    endtask

    task automatic test_back_to_back();
        int cyc; logic [31:0] r; logic [4:0] rdo; logic ln, st; bit early;
        drive(1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3);
        drive(1'b1, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4);
        wait_done(cyc, r, rdo, ln, st, early);
        checks++; if (cyc != 33 || ln !== 1'b0 || r !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL dual_first: got cyc=%0d lane=%b res=%h want 33/0/fffffffd", cyc, ln, r); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL dual_first_stall: got %b want 1", st); end
        @(posedge CLK); #1;
        wait_done(cyc, r, rdo, ln, st, early);
        checks++; if (cyc != 33 || ln !== 1'b1 || rdo !== 5'd4 || r !== ONES) begin
            errors++; $display("FAIL dual_second: got cyc=%0d lane=%b rd=%0d res=%h want 33/1/4/ffffffff", cyc, ln, rdo, r); end
        checks++; if (st !== 1'b0 || early) begin errors++; $display("FAIL dual_second_stall: got st=%b early=%b want 0/0", st, early); end
        release_reqs();
    endtask

    task automatic test_special();
        logic [2:0]  ops [4] = '{3'd5, 3'd6, 3'd4, 3'd7};
        logic [31:0] as  [4] = '{32'h1234_5678, MINV, MINV, 32'hCAFE_0001};
        logic [31:0] bs  [4] = '{32'd0, ONES, ONES, 32'd0};
        int cyc; logic [31:0] r; logic [4:0] rdo; logic ln, st; bit early;
        for (int i = 0; i < 4; i++) begin
            drive(i[0], ops[i], as[i], bs[i], 5'(i + 20));
            wait_done(cyc, r, rdo, ln, st, early);
            checks++; if (cyc != 1) begin errors++; $display("FAIL special_latency[%0d]: got %0d want 1", i, cyc); end
            checks++; if (r !== ref_result(ops[i], as[i], bs[i])) begin
                errors++; $display("FAIL special_result[%0d]: got %h want %h", i, r, ref_result(ops[i], as[i], bs[i])); end
            release_reqs();
        end
    endtask

    task automatic test_flush_mid();
        int cyc; logic [31:0] r; logic [4:0] rdo; logic ln, st; bit early; bit seen;
        seen = 0;
        drive(1'b0, 3'd4, 32'd1000, 32'd7, 5'd6);
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK); if (done !== 1'b0) seen = 1;
            @(posedge CLK); #1;
        end
        flush = 1'b1;
        @(negedge CLK); if (done !== 1'b0) seen = 1;
        checks++; if (seen) begin errors++; $display("FAIL flush_mid_done: got done=1 want 0"); end
        @(posedge CLK); #1;
        flush = 1'b0; req1 = 1'b0;
        @(negedge CLK);
        checks++; if (stall !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL flush_mid_idle: got stall=%b done=%b want 0/0", stall, done); end
        @(posedge CLK); #1;
        drive(1'b0, 3'd0, 32'd11, 32'd13, 5'd7);
        @(negedge CLK);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_stall_follow: got %b want 1", stall); end
        @(posedge CLK); #1;
        wait_done(cyc, r, rdo, ln, st, early);
        checks++; if (cyc != 32 || r !== 32'd143) begin
            errors++; $display("FAIL flush_after_op: got cyc=%0d res=%h want 32/0000008f", cyc, r); end
        release_reqs();
    endtask

    task automatic test_flush_fin();
        bit seen;
        seen = 0;
        drive(1'b1, 3'd1, $urandom, $urandom, 5'd12);
        for (int c = 0; c < 33; c++) begin
            @(negedge CLK); if (done !== 1'b0) seen = 1;
            @(posedge CLK); #1;
        end
        flush = 1'b1;
        @(negedge CLK);
        checks++; if (done !== 1'b0 || seen) begin errors++; $display("FAIL flush_fin_done: got done=%b early=%b want 0/0", done, seen); end
        @(posedge CLK); #1;
        flush = 1'b0; req2 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK); if (done !== 1'b0) seen = 1;
            @(posedge CLK); #1;
        end
        checks++; if (seen) begin errors++; $display("FAIL flush_fin_after: got done=1 want 0"); end
    endtask

    task automatic test_reset_mid();
        int cyc; logic [31:0] r; logic [4:0] rdo; logic ln, st; bit early;
        drive(1'b1, 3'd3, ONES, ONES, 5'd9);
        wait_done(cyc, r, rdo, ln, st, early);
        release_reqs();
        drive(1'b0, 3'd0, 32'd3, 32'd5, 5'd2);
        repeat (20) begin @(posedge CLK); #1; end
        RST = 1'b1; req1 = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        checks++; if ({done, stall, lane_out} !== 3'b000 || result !== 32'd0 || rd_out !== 5'd0) begin
            errors++; $display("FAIL reset_mid_outputs: got done=%b stall=%b lane=%b res=%h rd=%0d want all 0",
                               done, stall, lane_out, result, rd_out); end
        @(posedge CLK); #1;
        drive(1'b0, 3'd0, 32'd3, 32'd5, 5'd2);
        wait_done(cyc, r, rdo, ln, st, early);
        checks++; if (cyc != 33 || r !== 32'd15 || rdo !== 5'd2) begin
            errors++; $display("FAIL reset_mid_resume: got cyc=%0d res=%h rd=%0d want 33/0000000f/2", cyc, r, rdo); end
        release_reqs();
    endtask

    task automatic test_random();
        int cyc; logic [31:0] r; logic [4:0] rdo; logic ln, st; bit early;
        logic [2:0] op, opb; logic [31:0] a, b, aa, bb; logic [4:0] rd; bit lane2;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7)); a = pick_val(); b = pick_val();
            rd = 5'($urandom_range(1, 31)); lane2 = 1'($urandom_range(0, 1));
            drive(lane2, op, a, b, rd);
            wait_done(cyc, r, rdo, ln, st, early);
            checks++; if (r !== ref_result(op, a, b)) begin
                errors++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, r, ref_result(op, a, b)); end
            checks++; if (cyc != ref_latency(op, a, b) || ln !== lane2 || rdo !== rd || early) begin
                errors++; $display("FAIL rand_meta[%0d]: got cyc=%0d lane=%b rd=%0d early=%b want %0d/%b/%0d/0",
                                   i, cyc, ln, rdo, early, ref_latency(op, a, b), lane2, rd); end
            release_reqs();
        end
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 7)); a = pick_val(); b = pick_val();
            opb = 3'($urandom_range(0, 7)); aa = pick_val(); bb = pick_val();
            drive(1'b0, op, a, b, 5'd1);
            drive(1'b1, opb, aa, bb, 5'd2);
            wait_done(cyc, r, rdo, ln, st, early);
            checks++; if (ln !== 1'b0 || r !== ref_result(op, a, b) || cyc != ref_latency(op, a, b) || st !== 1'b1) begin
                errors++; $display("FAIL rand_dual_first[%0d]: got lane=%b res=%h cyc=%0d st=%b want 0/%h/%0d/1",
                                   i, ln, r, cyc, st, ref_result(op, a, b), ref_latency(op, a, b)); end
            @(posedge CLK); #1;
            wait_done(cyc, r, rdo, ln, st, early);
            checks++; if (ln !== 1'b1 || r !== ref_result(opb, aa, bb) || cyc != ref_latency(opb, aa, bb) || st !== 1'b0) begin
                errors++; $display("FAIL rand_dual_second[%0d]: got lane=%b res=%h cyc=%0d st=%b want 1/%h/%0d/0",
                                   i, ln, r, cyc, st, ref_result(opb, aa, bb), ref_latency(opb, aa, bb)); end
            release_reqs();
        end
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_mulh_lane2();
        test_back_to_back();
        test_special();
        test_flush_mid();
        test_flush_fin();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
